// File: rtl/traffic_light_monitor.sv
// Passive checker on four junction light buses: latches the first fault, counts faulting cycles.
// Latency: faults are flagged on the same edge that samples the offending lights. Backpressure: none.
// TLM_SAFE_OVERRIDE_EN adds force_red, held high in SYNC and while a fault is latched.
module traffic_light_monitor #(
    parameter int CNT_W      = 8,
    parameter int MIN_YELLOW = 3,
    parameter int MAX_YELLOW = 5,
    parameter int MAX_GREEN  = 10,
    parameter int MAX_RED    = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light_M1,
    input  logic [2:0]       light_M2,
    input  logic [2:0]       light_MT,
    input  logic [2:0]       light_S,
    input  logic             clr_fault,
    output logic             armed,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [1:0]       fault_road,
    output logic [CNT_W-1:0] fault_count
`ifdef TLM_SAFE_OVERRIDE_EN
    ,
    output logic             force_red
`endif
);

    localparam logic [2:0] LT_R = 3'b100;
    localparam logic [2:0] LT_Y = 3'b010;
    localparam logic [2:0] LT_G = 3'b001;

    localparam logic [2:0] C_NONE   = 3'd0;
    localparam logic [2:0] C_ENC    = 3'd1;
    localparam logic [2:0] C_CONF   = 3'd2;
    localparam logic [2:0] C_SEQ    = 3'd3;
    localparam logic [2:0] C_YSHORT = 3'd4;
    localparam logic [2:0] C_YLONG  = 3'd5;
    localparam logic [2:0] C_GLONG  = 3'd6;
    localparam logic [2:0] C_STARVE = 3'd7;

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_Y_C  = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_Y_C  = CNT_W'(MAX_YELLOW);
    localparam logic [CNT_W-1:0] MAX_G_C  = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] MAX_R_C  = CNT_W'(MAX_RED);

    function automatic logic is_legal(input logic [2:0] l);
        return (l == LT_R) || (l == LT_Y) || (l == LT_G);
    endfunction

    function automatic logic step_ok(input logic [2:0] p, input logic [2:0] c);
        return (p == c) || (p == LT_R && c == LT_G) || (p == LT_G && c == LT_Y) ||
               (p == LT_Y && c == LT_R);
    endfunction

    logic [1:0]                  state_q;
    logic [3:0][2:0]             cur;
    logic [3:0][2:0]             prev_q;
    logic [3:0][CNT_W-1:0]       cnt_q;
    logic [3:0]                  partial_q;
    logic [3:0][2:0]             road_code;
    logic [2:0]                  best_code;
    logic [1:0]                  best_road;
    logic                        s_conflict;
    logic                        mt_conflict;
    logic                        all_legal;
    logic                        checking;
    logic                        fault_any;

    // Index 0..3 follows the tie-break order M1, M2, MT, S.
    assign cur = {light_S, light_MT, light_M2, light_M1};

    assign s_conflict  = (cur[3] != LT_R) &&
                         ((cur[0] != LT_R) || (cur[1] != LT_R) || (cur[2] != LT_R));
    assign mt_conflict = (cur[2] == LT_G) && (cur[1] == LT_G);
    assign all_legal   = is_legal(cur[0]) && is_legal(cur[1]) &&
                         is_legal(cur[2]) && is_legal(cur[3]);
    assign checking    = (state_q != ST_SYNC);

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            road_code[r] = C_NONE;
            if (!is_legal(cur[r])) begin
                road_code[r] = C_ENC;
            end else if ((r == 3 && s_conflict) || (r == 2 && mt_conflict)) begin
                road_code[r] = C_CONF;
            // An illegal previous sample has no defined phase, so order is not judged against it.
            end else if (is_legal(prev_q[r]) && !step_ok(prev_q[r], cur[r])) begin
                road_code[r] = C_SEQ;
            end else if (prev_q[r] == LT_Y && cur[r] == LT_R &&
                         cnt_q[r] < MIN_Y_C && !partial_q[r]) begin
                road_code[r] = C_YSHORT;
            end else if (prev_q[r] == cur[r] && cur[r] == LT_Y && cnt_q[r] >= MAX_Y_C) begin
                road_code[r] = C_YLONG;
            end else if (prev_q[r] == cur[r] && cur[r] == LT_G && cnt_q[r] >= MAX_G_C) begin
                road_code[r] = C_GLONG;
            end else if (prev_q[r] == cur[r] && cur[r] == LT_R && cnt_q[r] >= MAX_R_C) begin
                road_code[r] = C_STARVE;
            end
        end
    end

    always_comb begin
        best_code = C_NONE;
        best_road = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (road_code[r] != C_NONE && (best_code == C_NONE || road_code[r] < best_code)) begin
                best_code = road_code[r];
                best_road = 2'(r);
            end
        end
    end

    assign fault_any = checking && (best_code != C_NONE);

    // While unsynchronised every road restarts as a partial phase of length 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= '0;
            cnt_q     <= '0;
            partial_q <= '0;
        end else begin
            for (int r = 0; r < 4; r++) begin
                prev_q[r] <= cur[r];
                if (!checking) begin
                    cnt_q[r]     <= CNT_ONE;
                    partial_q[r] <= 1'b1;
                end else if (cur[r] != prev_q[r]) begin
                    cnt_q[r]     <= CNT_ONE;
                    partial_q[r] <= 1'b0;
                end else if (cnt_q[r] != CNT_MAX) begin
                    cnt_q[r] <= cnt_q[r] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            fault_code  <= C_NONE;
            fault_road  <= 2'd0;
            fault_count <= '0;
        end else begin
            if (fault_any && fault_count != CNT_MAX) begin
                fault_count <= fault_count + CNT_ONE;
            end
            case (state_q)
                ST_SYNC: begin
                    if (all_legal) begin
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (fault_any) begin
                        state_q    <= ST_FAULT;
                        fault_code <= best_code;
                        fault_road <= best_road;
                    end
                end
                ST_FAULT: begin
                    // A fault arriving with the clear is captured fresh rather than dropped.
                    if (clr_fault) begin
                        if (fault_any) begin
                            fault_code <= best_code;
                            fault_road <= best_road;
                        end else begin
                            state_q    <= ST_ARMED;
                            fault_code <= C_NONE;
                            fault_road <= 2'd0;
                        end
                    end
                end
                default: state_q <= ST_SYNC;
            endcase
        end
    end

    assign armed = (state_q != ST_SYNC);
    assign fault = (state_q == ST_FAULT);

`ifdef TLM_SAFE_OVERRIDE_EN
    assign force_red = (state_q == ST_FAULT) || (state_q == ST_SYNC);
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: expectations queued per driven cycle, compared after the edge.
module tb_traffic_light_monitor;

    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] BAD = 3'b011;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] light_M1 = R;
    logic [2:0] light_M2 = R;
    logic [2:0] light_MT = R;
    logic [2:0] light_S  = R;
    logic       clr_fault = 1'b0;
    logic       armed;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_road;
    logic [7:0] fault_count;
`ifdef TLM_SAFE_OVERRIDE_EN
    logic       force_red;
`endif

    traffic_light_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .light_M1    (light_M1),
        .light_M2    (light_M2),
        .light_MT    (light_MT),
        .light_S     (light_S),
        .clr_fault   (clr_fault),
        .armed       (armed),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_road  (fault_road),
        .fault_count (fault_count)
`ifdef TLM_SAFE_OVERRIDE_EN
        ,
        .force_red   (force_red)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       armed;
        logic       fault;
        logic [2:0] code;
        logic [1:0] road;
        logic [7:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_no  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", tag, step_no, got, want);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty step %0d", step_no);
        end else begin
            e = exp_q.pop_front();
            check("armed", armed, e.armed);
            check("fault", fault, e.fault);
            check("fault_code", fault_code, e.code);
            check("fault_road", fault_road, e.road);
            check("fault_count", fault_count, e.count);
`ifdef TLM_SAFE_OVERRIDE_EN
            check("force_red", force_red, !e.armed || e.fault);
`endif
        end
    endtask

    task automatic step(input logic [2:0] m1, input logic [2:0] m2, input logic [2:0] mt,
                        input logic [2:0] s, input logic clr, input logic ea, input logic ef,
                        input logic [2:0] ec, input logic [1:0] er, input logic [7:0] en);
        exp_t e;
        light_M1  = m1;
        light_M2  = m2;
        light_MT  = mt;
        light_S   = s;
        clr_fault = clr;
        e = '{armed: ea, fault: ef, code: ec, road: er, count: en};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
        step_no++;
    endtask

    // Reset must clear outputs asynchronously, before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_armed", armed, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_code", fault_code, 3'd0);
        check("rst_road", fault_road, 2'd0);
        check("rst_count", fault_count, 8'd0);
`ifdef TLM_SAFE_OVERRIDE_EN
        check("rst_force_red", force_red, 1'b1);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Legal 29-cycle plan: M1/M2 G10 Y3, then MT G5 Y3, then S G5 Y3; no road red beyond 30.
    function automatic logic [11:0] cyc_lights(input int t);
        logic [2:0] m;
        logic [2:0] mt;
        logic [2:0] s;
        m  = R;
        mt = R;
        s  = R;
        if (t < 10)      m  = G;
        else if (t < 13) m  = Y;
        else if (t < 18) mt = G;
        else if (t < 21) mt = Y;
        else if (t < 26) s  = G;
        else             s  = Y;
        return {m, m, mt, s};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [11:0] lt;
        #2;
        do_reset();

        // Arm on an all-red sample, then run the legal plan for 203 cycles.
        step(R, R, R, R, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
        for (int i = 0; i < 203; i++) begin
            lt = cyc_lights(i % 29);
            step(lt[11:9], lt[8:6], lt[5:3], lt[2:0], 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
        end
        step(G, G, R, R, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0);

        // S green against M1 green: conflict on road S; clear while it persists keeps the fault.
        step(G, G, R, G, 1'b0, 1'b1, 1'b1, 3'd2, 2'd3, 8'd1);
        step(G, G, R, G, 1'b0, 1'b1, 1'b1, 3'd2, 2'd3, 8'd2);
        step(G, G, R, G, 1'b1, 1'b1, 1'b1, 3'd2, 2'd3, 8'd3);
        do_reset();

        // M2 yellow for only two cycles, then clear.
        step(R, R, R, R, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
        step(G, G, R, R, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
        step(G, Y, R, R, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
        step(G, Y, R, R, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
        step(G, R, R, R, 1'b0, 1'b1, 1'b1, 3'd4, 2'd1, 8'd1);
        step(Y, R, R, R, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 8'd1);

        // MT illegal encoding; S conflict added later does not displace the captured code.
        step(Y, R, BAD, R, 1'b0, 1'b1, 1'b1, 3'd1, 2'd2, 8'd2);
        step(Y, R, BAD, R, 1'b0, 1'b1, 1'b1, 3'd1, 2'd2, 8'd3);
        step(Y, R, BAD, G, 1'b0, 1'b1, 1'b1, 3'd1, 2'd2, 8'd4);
        step(Y, R, BAD, G, 1'b0, 1'b1, 1'b1, 3'd1, 2'd2, 8'd5);
        // Clear with new faults present: conflict (code 2) outranks M1 yellow-long (code 5).
        step(Y, R, R, G, 1'b1, 1'b1, 1'b1, 3'd2, 2'd3, 8'd6);
        step(Y, R, R, G, 1'b0, 1'b1, 1'b1, 3'd2, 2'd3, 8'd7);
        do_reset();

        // Illegal inputs keep the monitor in SYNC; starvation fires on the 31st red sample.
        step(BAD, R, R, R, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 8'd0);
        step(R, R, R, R, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
        for (int i = 0; i < 29; i++) begin
            step(R, R, R, R, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
        end
        step(R, R, R, R, 1'b0, 1'b1, 1'b1, 3'd7, 2'd0, 8'd1);
        do_reset();

        // Green of exactly MAX_GREEN is legal; one more cycle is not. Then an order violation.
        step(R, R, R, R, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            step(G, R, R, R, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
        end
        step(G, R, R, R, 1'b0, 1'b1, 1'b1, 3'd6, 2'd0, 8'd1);
        step(Y, R, R, R, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 8'd1);
        step(G, R, R, R, 1'b0, 1'b1, 1'b1, 3'd3, 2'd0, 8'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
